dbus_arbiter: RTL and testbench

Two-master data-bus arbiter and address decoder between the requesters (core data port as master 0, program loader / debug master as master 1) and two slaves: data memory and the memory-mapped I/O region (SPI I/O and future peripherals). It grants one single-beat access per cycle with round-robin fairness. It routes the selected request to the decoded slave and returns the one-cycle-latency read data to the master that owns it. It replaces ad-hoc read-data precedence muxing at the top level.

---
 rtl/dbus_arbiter.sv | 111 +++++++++++
 tb/tb_dbus_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_arbiter.sv
// Two-master, single-beat data-bus arbiter with round-robin tie breaking,
// I/O vs data-memory address decode and one-cycle read-response routing.
module dbus_arbiter #(
  parameter logic [31:0] IO_BASE = 32'h8000_0000,
  parameter logic [31:0] IO_MASK = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic        m0_we,
  input  logic [31:0] m0_wdata,
  input  logic [1:0]  m0_mask,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic        m1_we,
  input  logic [31:0] m1_wdata,
  input  logic [1:0]  m1_mask,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_mask,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  output logic [31:0] io_addr,
  output logic [31:0] io_wdata,
  output logic [1:0]  io_mask,
  output logic        io_we,
  output logic        io_re,
  input  logic [31:0] io_rdata
);

  logic        last_q, last_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_owner_q, rsp_owner_d;
  logic        rsp_io_q, rsp_io_d;

  logic        grant;
  logic        win;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [1:0]  sel_mask;
  logic        sel_we;
  logic        sel_io;

  // NOTE: every signal gets a value at the top of always_comb so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    grant = (m0_req | m1_req) & ~rst;
    // A tie goes to the master that did not win last; with no request the
    // winner defaults to master 0 so the slave fields come from m0.
    win = (m0_req & m1_req) ? ~last_q : m1_req;

    sel_addr  = win ? m1_addr  : m0_addr;
    sel_wdata = win ? m1_wdata : m0_wdata;
    sel_mask  = win ? m1_mask  : m0_mask;
    sel_we    = win ? m1_we    : m0_we;
    sel_io    = (sel_addr & IO_MASK) == IO_BASE;

    m0_gnt = grant & ~win;
    m1_gnt = grant & win;

    mem_addr  = sel_addr;
    mem_wdata = sel_wdata;
    mem_mask  = sel_mask;
    io_addr   = sel_addr;
    io_wdata  = sel_wdata;
    io_mask   = sel_mask;

    mem_we = grant & ~sel_io & sel_we;
    mem_re = grant & ~sel_io & ~sel_we;
    io_we  = grant & sel_io & sel_we;
    io_re  = grant & sel_io & ~sel_we;

    last_d      = grant ? win : last_q;
    rsp_valid_d = grant & ~sel_we;
    rsp_owner_d = rsp_valid_d ? win    : rsp_owner_q;
    rsp_io_d    = rsp_valid_d ? sel_io : rsp_io_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= 1'b0;
      rsp_io_q    <= 1'b0;
    end else begin
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_owner_q <= rsp_owner_d;
      rsp_io_q    <= rsp_io_d;
    end
  end

  // Read data is shared; each master qualifies it with its own rvalid.
  always_comb begin
    m0_rdata  = rsp_io_q ? io_rdata : mem_rdata;
    m1_rdata  = m0_rdata;
    m0_rvalid = rsp_valid_q & ~rsp_owner_q;
    m1_rvalid = rsp_valid_q & rsp_owner_q;
  end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter: directed vector table, reset corner sequences and
// a randomized run against a behavioural arbitration model.
module tb_dbus_arbiter;

  localparam logic [31:0] IO_BASE = 32'h8000_0000;
  localparam logic [31:0] IO_MASK = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [1:0]  m0_mask, m1_mask;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_addr, mem_wdata, io_addr, io_wdata;
  logic [1:0]  mem_mask, io_mask;
  logic        mem_we, mem_re, io_we, io_re;
  logic [31:0] mem_rdata, io_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dbus_arbiter #(.IO_BASE(IO_BASE), .IO_MASK(IO_MASK)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
    .m0_mask(m0_mask), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
    .m1_mask(m1_mask), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mask(mem_mask),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_mask(io_mask),
    .io_we(io_we), .io_re(io_re), .io_rdata(io_rdata)
  );

  typedef struct {
    logic        r0;
    logic [31:0] a0;
    logic        w0;
    logic        r1;
    logic [31:0] a1;
    logic        w1;
    logic [1:0]  gnt;  // {m1_gnt, m0_gnt}
    logic [3:0]  stb;  // {io_we, io_re, mem_we, mem_re}
    logic [1:0]  rv;   // {m1_rvalid, m0_rvalid}
    logic        rio;  // response expected from I/O
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // The strobed slave must carry the winner's request fields.
  task automatic check_fields(input string tag, input logic w, input logic to_io);
    logic [31:0] ea, ed;
    logic [1:0]  em;
    ea = w ? m1_addr  : m0_addr;
    ed = w ? m1_wdata : m0_wdata;
    em = w ? m1_mask  : m0_mask;
    if (to_io) begin
      check({tag, "_io_addr"},  io_addr,  ea);
      check({tag, "_io_wdata"}, io_wdata, ed);
      check({tag, "_io_mask"},  {30'd0, io_mask}, {30'd0, em});
    end else begin
      check({tag, "_mem_addr"},  mem_addr,  ea);
      check({tag, "_mem_wdata"}, mem_wdata, ed);
      check({tag, "_mem_mask"},  {30'd0, mem_mask}, {30'd0, em});
    end
  endtask

  task automatic rand_data();
    m0_wdata  = $urandom;
    m1_wdata  = $urandom;
    m0_mask   = 2'($urandom_range(0, 2));
    m1_mask   = 2'($urandom_range(0, 2));
    mem_rdata = $urandom;
    io_rdata  = $urandom;
  endtask

  task automatic idle();
    m0_req = 1'b0; m0_addr = '0; m0_we = 1'b0;
    m1_req = 1'b0; m1_addr = '0; m1_we = 1'b0;
    rand_data();
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic        act[2];
  logic [31:0] raddr[2];
  logic        rwe[2];
  logic [31:0] rwd[2];
  logic [1:0]  rmk[2];
  int          wait_cnt[2];

  initial begin
    // Directed table, starting from a freshly reset arbiter (last = 1).
    tbl[0]  = '{1, 32'h0000_0010, 0, 0, 32'h0,         0, 2'b01, 4'b0001, 2'b00, 0};
    tbl[1]  = '{1, 32'h0000_0020, 0, 1, 32'h8000_0004, 0, 2'b10, 4'b0100, 2'b01, 0};
    tbl[2]  = '{1, 32'h0000_0020, 0, 1, 32'h8000_0004, 0, 2'b01, 4'b0001, 2'b10, 1};
    tbl[3]  = '{1, 32'h0000_0024, 0, 1, 32'h8000_0008, 0, 2'b10, 4'b0100, 2'b01, 0};
    tbl[4]  = '{0, 32'h0,         0, 1, 32'h8000_0000, 1, 2'b10, 4'b1000, 2'b10, 1};
    tbl[5]  = '{0, 32'h0,         0, 1, 32'h7FFF_FFFC, 0, 2'b10, 4'b0001, 2'b00, 0};
    tbl[6]  = '{0, 32'h0,         0, 0, 32'h0,         0, 2'b00, 4'b0000, 2'b10, 0};
    tbl[7]  = '{1, 32'h8000_0010, 1, 1, 32'h0000_0008, 0, 2'b01, 4'b1000, 2'b00, 0};
    tbl[8]  = '{0, 32'h0,         0, 1, 32'h0000_0008, 0, 2'b10, 4'b0001, 2'b00, 0};
    tbl[9]  = '{0, 32'h0,         0, 0, 32'h0,         0, 2'b00, 4'b0000, 2'b10, 0};
    tbl[10] = '{1, 32'h0000_0000, 0, 0, 32'h0,         0, 2'b01, 4'b0001, 2'b00, 0};
    tbl[11] = '{1, 32'h8000_0004, 0, 0, 32'h0,         0, 2'b01, 4'b0100, 2'b01, 0};
    tbl[12] = '{1, 32'h0000_0008, 0, 0, 32'h0,         0, 2'b01, 4'b0001, 2'b01, 1};
    tbl[13] = '{0, 32'h0,         0, 0, 32'h0,         0, 2'b00, 4'b0000, 2'b01, 0};

    // Reset held with a live request: nothing may be granted or strobed.
    rst = 1'b1;
    idle();
    m0_req = 1'b1; m0_addr = 32'h10;
    next_cycle();
    @(negedge clk);
    check("rst_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
    check("rst_stb", {28'd0, io_we, io_re, mem_we, mem_re}, 32'd0);
    check("rst_rv",  {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    next_cycle();
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      rand_data();
      m0_req = tbl[i].r0; m0_addr = tbl[i].a0; m0_we = tbl[i].w0;
      m1_req = tbl[i].r1; m1_addr = tbl[i].a1; m1_we = tbl[i].w1;
      if (i == 4) begin
        m1_wdata = 32'hA5;
        m1_mask  = 2'b00;
      end
      @(negedge clk);
      check($sformatf("t%0d_gnt", i), {30'd0, m1_gnt, m0_gnt}, {30'd0, tbl[i].gnt});
      check($sformatf("t%0d_stb", i), {28'd0, io_we, io_re, mem_we, mem_re}, {28'd0, tbl[i].stb});
      check($sformatf("t%0d_rv", i),  {30'd0, m1_rvalid, m0_rvalid}, {30'd0, tbl[i].rv});
      if (tbl[i].rv[0])
        check($sformatf("t%0d_rd0", i), m0_rdata, tbl[i].rio ? io_rdata : mem_rdata);
      if (tbl[i].rv[1])
        check($sformatf("t%0d_rd1", i), m1_rdata, tbl[i].rio ? io_rdata : mem_rdata);
      if (tbl[i].gnt != 2'b00)
        check_fields($sformatf("t%0d", i), tbl[i].gnt[1], tbl[i].stb[3] | tbl[i].stb[2]);
      next_cycle();
    end

    // Reset in the cycle after a read grant drops the pending response.
    idle();
    m0_req = 1'b1; m0_addr = 32'h40;
    @(negedge clk);
    check("mr_gnt", {31'd0, m0_gnt}, 32'd1);
    next_cycle();
    idle();
    rst = 1'b1;
    @(negedge clk);
    check("mr_rv_in_rst", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    next_cycle();
    rst = 1'b0;
    m0_req = 1'b1; m0_addr = 32'h100;
    m1_req = 1'b1; m1_addr = 32'h200;
    @(negedge clk);
    check("mr_rv_after", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    check("mr_tie_gnt",  {30'd0, m1_gnt, m0_gnt}, 32'd1);
    next_cycle();
    idle();
    @(negedge clk);
    check("mr_new_rv0", {30'd0, m1_rvalid, m0_rvalid}, 32'd1);
    check("mr_new_rd0", m0_rdata, mem_rdata);
    next_cycle();

    // Randomized traffic against a behavioural model, from a fresh reset.
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    begin
      int  last_id = 1;
      logic pv = 1'b0;
      int  po = 0;
      logic pio = 1'b0;
      for (int m = 0; m < 2; m++) begin
        act[m] = 1'b0;
        wait_cnt[m] = 0;
      end
      for (int cyc = 0; cyc < 400; cyc++) begin
        int w;
        logic eio;
        logic [1:0] dg;
        for (int m = 0; m < 2; m++) begin
          // Master 0 is nearly always busy to stress fairness.
          if (!act[m] && $urandom_range(0, 99) < (m == 0 ? 90 : 40)) begin
            act[m] = 1'b1;
            case ($urandom_range(0, 3))
              0:       raddr[m] = IO_BASE;
              1:       raddr[m] = IO_BASE - 32'd1;
              2:       raddr[m] = $urandom | IO_BASE;
              default: raddr[m] = $urandom & ~IO_BASE;
            endcase
            rwe[m] = 1'($urandom_range(0, 1));
            rwd[m] = $urandom;
            rmk[m] = 2'($urandom_range(0, 2));
          end
        end
        m0_req = act[0]; m0_addr = raddr[0]; m0_we = rwe[0]; m0_wdata = rwd[0]; m0_mask = rmk[0];
        m1_req = act[1]; m1_addr = raddr[1]; m1_we = rwe[1]; m1_wdata = rwd[1]; m1_mask = rmk[1];
        mem_rdata = $urandom;
        io_rdata  = $urandom;

        if (act[0] && act[1]) w = 1 - last_id;
        else if (act[0])      w = 0;
        else if (act[1])      w = 1;
        else                  w = -1;
        eio = (w >= 0) && ((raddr[w] & IO_MASK) == IO_BASE);

        @(negedge clk);
        check("r_gnt", {30'd0, m1_gnt, m0_gnt}, {30'd0, w == 1, w == 0});
        check("r_stb", {28'd0, io_we, io_re, mem_we, mem_re},
              {28'd0, (w >= 0) && eio && rwe[w], (w >= 0) && eio && !rwe[w],
                      (w >= 0) && !eio && rwe[w], (w >= 0) && !eio && !rwe[w]});
        check("r_rv", {30'd0, m1_rvalid, m0_rvalid}, {30'd0, pv && po == 1, pv && po == 0});
        if (pv)
          check("r_rdata", po == 1 ? m1_rdata : m0_rdata, pio ? io_rdata : mem_rdata);
        if (w >= 0)
          check_fields("r", w == 1, eio);

        dg = {m1_gnt, m0_gnt};
        for (int m = 0; m < 2; m++) begin
          if (act[m] && !dg[m]) begin
            wait_cnt[m]++;
            if (wait_cnt[m] > 1) begin
              errors++;
              $display("FAIL r_fair: master %0d waited %0d slots, allowed 1", m, wait_cnt[m]);
            end
            checks++;
          end else begin
            wait_cnt[m] = 0;
          end
        end

        pv = (w >= 0) && !rwe[w];
        if (w >= 0) begin
          po = w;
          pio = eio;
          last_id = w;
          act[w] = 1'b0;
        end
        next_cycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
